// File: rtl/game_pkg.sv
// Shared game-level encodings and boss tuning constants.
package game_pkg;

   localparam logic [1:0] GAME_MENU = 2'd0;
   localparam logic [1:0] GAME_PLAY = 2'd1;
   localparam logic [1:0] GAME_END  = 2'd2;

   typedef enum logic [2:0] {
      IDLE,
      ALIVE,
      INVULN,
      DYING,
      DEAD
   } boss_state_t;

   localparam int DEF_MAX_HP       = 128;
   localparam int DEF_HP_SHIFT     = 7;
   localparam int DEF_MELEE_DMG    = 4;
   localparam int DEF_PROJ_DMG     = 2;
   localparam int DEF_INV_FRAMES   = 8;
   localparam int DEF_DEATH_FRAMES = 30;
   localparam int DEF_BAR_W        = 256;

endpackage

// File: rtl/boss_hit_edge.sv
// Two-channel rising-edge detector; history register cleared by sync reset.
module boss_hit_edge
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_hit,
   output logic [1:0] o_edge
);

   logic [1:0] r_prev;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_prev <= 2'b00;
      else          r_prev <= i_hit;
   end

   assign o_edge = i_hit & ~r_prev;

endmodule

// File: rtl/boss_damage_ctl.sv
// Boss HP owner: damage application, invulnerability, death sequence, HP bar.
module boss_damage_ctl
   import game_pkg::*;
#(
   parameter int MAX_HP       = DEF_MAX_HP,
   parameter int HP_SHIFT     = DEF_HP_SHIFT,
   parameter int MELEE_DMG    = DEF_MELEE_DMG,
   parameter int PROJ_DMG     = DEF_PROJ_DMG,
   parameter int INV_FRAMES   = DEF_INV_FRAMES,
   parameter int DEATH_FRAMES = DEF_DEATH_FRAMES,
   parameter int BAR_W        = DEF_BAR_W
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                frame_tick,
   input  logic [1:0]          game_active,
   input  logic                projectile_hit,
   input  logic                melee_hit,
   output logic [HP_SHIFT:0]   boss_hp,
   output logic                boss_alive,
   output logic                boss_hit_flash,
   output logic                boss_dying,
   output logic                boss_defeated,
   output logic [9:0]          hp_bar_w
);

   localparam int HPW   = HP_SHIFT + 1;
   localparam int CMAX  = (INV_FRAMES > DEATH_FRAMES) ? INV_FRAMES : DEATH_FRAMES;
   localparam int CNT_W = $clog2(CMAX + 1);
   localparam int PW    = HPW + 11;

   localparam logic [HPW-1:0]   HP_FULL = HPW'(MAX_HP);
   localparam logic [CNT_W-1:0] C_INV   = CNT_W'(INV_FRAMES);
   localparam logic [CNT_W-1:0] C_DEATH = CNT_W'(DEATH_FRAMES);
   localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

   boss_state_t      r_state, w_state_n;
   logic [CNT_W-1:0] r_cnt, w_cnt_n;
   logic [HPW-1:0]   r_hp, w_hp_n, w_dmg, w_hp_sub;
   logic [9:0]       r_bar, w_bar;
   logic             r_alive, r_flash, r_dying, r_def, w_def_n;
   logic [1:0]       w_edge;
   logic             w_hit;

   boss_hit_edge u_edge (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_hit   ({melee_hit, projectile_hit}),
      .o_edge  (w_edge)
   );

   assign w_hit    = |w_edge;
   assign w_dmg    = (w_edge[1] ? HPW'(MELEE_DMG) : '0)
                   + (w_edge[0] ? HPW'(PROJ_DMG) : '0);
   assign w_hp_sub = (r_hp > w_dmg) ? r_hp - w_dmg : '0;
   assign w_bar    = 10'((PW'(r_hp) * PW'(BAR_W)) >> HP_SHIFT);

   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_hp_n    = r_hp;
      w_def_n   = 1'b0;
      // Leaving gameplay overrides hits and counter expiry.
      if (r_state != IDLE && game_active != GAME_PLAY) begin
         w_state_n = IDLE;
         w_cnt_n   = '0;
         w_hp_n    = HP_FULL;
      end else begin
         unique case (r_state)
            IDLE: begin
               w_hp_n = HP_FULL;
               if (game_active == GAME_PLAY) w_state_n = ALIVE;
            end
            ALIVE: begin
               if (w_hit) begin
                  w_hp_n = w_hp_sub;
                  if (w_hp_sub == '0) begin
                     w_state_n = DYING;
                     w_cnt_n   = C_DEATH;
                     w_def_n   = 1'b1;
                  end else begin
                     w_state_n = INVULN;
                     w_cnt_n   = C_INV;
                  end
               end
            end
            INVULN: begin
               if (frame_tick) begin
                  w_cnt_n = r_cnt - C_ONE;
                  if (r_cnt == C_ONE) w_state_n = ALIVE;
               end
            end
            DYING: begin
               w_hp_n = '0;
               if (frame_tick) begin
                  w_cnt_n = r_cnt - C_ONE;
                  if (r_cnt == C_ONE) w_state_n = DEAD;
               end
            end
            DEAD: w_hp_n = '0;
            default: begin
               w_state_n = IDLE;
               w_cnt_n   = '0;
               w_hp_n    = HP_FULL;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_hp    <= HP_FULL;
         r_bar   <= 10'(BAR_W);
         r_alive <= 1'b0;
         r_flash <= 1'b0;
         r_dying <= 1'b0;
         r_def   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_hp    <= w_hp_n;
         r_bar   <= w_bar;
         r_alive <= (w_state_n == ALIVE) || (w_state_n == INVULN);
         r_flash <= (w_state_n == INVULN);
         r_dying <= (w_state_n == DYING);
         r_def   <= w_def_n;
      end
   end

   assign boss_hp        = r_hp;
   assign boss_alive     = r_alive;
   assign boss_hit_flash = r_flash;
   assign boss_dying     = r_dying;
   assign boss_defeated  = r_def;
   assign hp_bar_w       = r_bar;

endmodule

// File: tb/tb_boss_damage_ctl.sv
// Scoreboard bench: random and directed play against a frame-level boss model.
module tb_boss_damage_ctl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       frame_tick = 1'b0;
   logic [1:0] game_active = 2'd0;
   logic       projectile_hit = 1'b0;
   logic       melee_hit = 1'b0;
   logic [7:0] boss_hp;
   logic       boss_alive, boss_hit_flash, boss_dying, boss_defeated;
   logic [9:0] hp_bar_w;

   int checks = 0;
   int errors = 0;

   boss_damage_ctl dut (
      .clk            (clk),
      .rst            (rst),
      .frame_tick     (frame_tick),
      .game_active    (game_active),
      .projectile_hit (projectile_hit),
      .melee_hit      (melee_hit),
      .boss_hp        (boss_hp),
      .boss_alive     (boss_alive),
      .boss_hit_flash (boss_hit_flash),
      .boss_dying     (boss_dying),
      .boss_defeated  (boss_defeated),
      .hp_bar_w       (hp_bar_w)
   );

   always #5 clk = ~clk;

   typedef struct {
      int hp;
      int bar;
      int alive;
      int flash;
      int dying;
      int def;
   } exp_t;

   exp_t q[$];

   // Model: boss phase, hit points, frames remaining, last hit levels.
   localparam int P_IDLE = 0, P_FIGHT = 1, P_STUN = 2, P_DIE = 3, P_DONE = 4;
   int m_phase = P_IDLE;
   int m_hp = 128;
   int m_left = 0;
   int m_pm = 0, m_pp = 0;
   int n_kills = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic r, input logic [1:0] g, input logic t,
                      input logic m, input logic p);
      exp_t e;
      int   me, pe, dmg, old_hp, def;
      @(negedge clk);
      rst = r; game_active = g; frame_tick = t;
      melee_hit = m; projectile_hit = p;
      def = 0;
      old_hp = m_hp;
      if (!r) begin
         m_phase = P_IDLE; m_hp = 128; m_left = 0; m_pm = 0; m_pp = 0;
         e.bar = 256;
      end else begin
         me = (m && !m_pm) ? 1 : 0;
         pe = (p && !m_pp) ? 1 : 0;
         m_pm = m; m_pp = p;
         e.bar = old_hp * 256 / 128;
         if (m_phase != P_IDLE && g != 2'd1) begin
            m_phase = P_IDLE; m_hp = 128; m_left = 0;
         end else if (m_phase == P_IDLE) begin
            if (g == 2'd1) m_phase = P_FIGHT;
         end else if (m_phase == P_FIGHT) begin
            if (me || pe) begin
               dmg = 4 * me + 2 * pe;
               m_hp = (m_hp > dmg) ? m_hp - dmg : 0;
               if (m_hp == 0) begin
                  m_phase = P_DIE; m_left = 30; def = 1; n_kills++;
               end else begin
                  m_phase = P_STUN; m_left = 8;
               end
            end
         end else if (m_phase == P_STUN || m_phase == P_DIE) begin
            if (t) begin
               m_left--;
               if (m_left == 0) m_phase = (m_phase == P_STUN) ? P_FIGHT : P_DONE;
            end
         end
      end
      e.hp    = m_hp;
      e.alive = (m_phase == P_FIGHT || m_phase == P_STUN) ? 1 : 0;
      e.flash = (m_phase == P_STUN) ? 1 : 0;
      e.dying = (m_phase == P_DIE) ? 1 : 0;
      e.def   = def;
      q.push_back(e);
   endtask

   // Monitor: one expected record per clock once stimulus has started.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("boss_hp", int'(boss_hp), e.hp);
            chk("hp_bar_w", int'(hp_bar_w), e.bar);
            chk("boss_alive", int'(boss_alive), e.alive);
            chk("boss_hit_flash", int'(boss_hit_flash), e.flash);
            chk("boss_dying", int'(boss_dying), e.dying);
            chk("boss_defeated", int'(boss_defeated), e.def);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic kill_boss();
      for (int i = 0; i < 200 && m_phase != P_DIE; i++) begin
         cyc(1, 1, 1, 1, 0);
         cyc(1, 1, 1, 0, 0);
         for (int k = 0; k < 9 && m_phase == P_STUN; k++) cyc(1, 1, 1, 0, 0);
      end
   endtask

   initial begin
      logic [1:0] g;
      logic       m, p, r, t;
      int         tick_pct, hit_pct, len;

      // Reset, start play, single held melee, projectile during stun.
      repeat (3) cyc(0, 1, 0, 0, 0);
      repeat (2) cyc(1, 1, 0, 0, 0);
      repeat (5) cyc(1, 1, 0, 1, 0);
      cyc(1, 1, 1, 0, 1);
      cyc(1, 1, 0, 0, 0);
      repeat (10) begin
         cyc(1, 1, 1, 0, 0);
         cyc(1, 1, 0, 0, 0);
      end

      // Coincident melee and projectile from full HP.
      cyc(0, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 1, 1);
      repeat (3) cyc(1, 1, 0, 0, 0);

      // Full kill, death animation, dead, then back to menu.
      kill_boss();
      cyc(1, 1, 1, 1, 0);
      repeat (33) cyc(1, 1, 1, 0, 0);
      cyc(1, 1, 0, 1, 1);
      repeat (2) cyc(1, 0, 0, 0, 0);

      // Menu mid-stun and mid-death.
      repeat (2) cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 1, 1, 0);
      repeat (3) cyc(1, 1, 1, 0, 0);
      cyc(1, 0, 1, 0, 0);
      repeat (2) cyc(1, 1, 0, 0, 0);
      kill_boss();
      repeat (5) cyc(1, 1, 1, 0, 0);
      cyc(1, 2, 1, 0, 1);
      repeat (2) cyc(1, 1, 0, 0, 0);

      // Reset mid-death with a coincident hit edge.
      kill_boss();
      repeat (4) cyc(1, 1, 1, 0, 0);
      cyc(0, 1, 1, 1, 1);
      repeat (3) cyc(1, 1, 0, 1, 1);

      // Randomized segments.
      g = 2'd1; m = 0; p = 0;
      for (int s = 0; s < 40; s++) begin
         tick_pct = $urandom_range(5, 100);
         hit_pct  = $urandom_range(5, 60);
         len      = $urandom_range(200, 700);
         for (int c = 0; c < len; c++) begin
            r = ($urandom_range(0, 2999) != 0);
            if ($urandom_range(0, 1999) == 0) g = 2'($urandom_range(0, 3));
            else if (g != 2'd1 && $urandom_range(0, 19) == 0) g = 2'd1;
            t = ($urandom_range(1, 100) <= tick_pct);
            if ($urandom_range(1, 100) <= hit_pct) m = ~m;
            if ($urandom_range(1, 100) <= hit_pct) p = ~p;
            cyc(r, g, t, m, p);
         end
      end

      repeat (3) cyc(1, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      chk("queue_drained", q.size(), 0);
      chk("kill_count_min", (n_kills >= 3) ? 1 : 0, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
